// File: rtl/wb_pkg.sv
// Shared types and constants for the MEM/WB writeback stage.
package wb_pkg;

    localparam int unsigned XLEN_DEF = 32;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_result_stage_load_extend.sv
// Combinational load alignment and sign/zero extension for sub-word loads.
module load_extend
    import wb_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  b8;
    logic [15:0] h16;

    always_comb begin
        b8         = rdata[{off, 3'b000} +: 8];
        h16        = rdata[{off[1], 4'b0000} +: 16];
        data       = '0;
        misaligned = 1'b0;
        case (funct3)
            F3_LB:  data = {{(XLEN-8){b8[7]}}, b8};
            F3_LBU: data = {{(XLEN-8){1'b0}}, b8};
            F3_LH: begin
                misaligned = off[0];
                data       = {{(XLEN-16){h16[15]}}, h16};
            end
            F3_LHU: begin
                misaligned = off[0];
                data       = {{(XLEN-16){1'b0}}, h16};
            end
            F3_LW: begin
                misaligned = (off != 2'b00);
                data       = rdata;
            end
            default: data = '0;
        endcase
        if (misaligned) data = '0;
    end

endmodule

// File: rtl/writeback_result_stage.sv
// Registered MEM/WB stage: result source mux, load extension and stall/flush-controlled
// pipeline register feeding the register file and the WB->EX forwarding path.
module writeback_result_stage
    import wb_pkg::*;
#(
    parameter int unsigned XLEN      = XLEN_DEF,
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned SRC_SEL_W = $clog2(NUM_SRC)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 stall_i,
    input  logic                 flush_i,
    input  logic                 valid_i,
    input  logic [SRC_SEL_W-1:0] result_src_i,
    input  logic [XLEN-1:0]      alu_result_i,
    input  logic [XLEN-1:0]      mem_rdata_i,
    input  logic [XLEN-1:0]      pc_plus4_i,
    input  logic [XLEN-1:0]      imm_i,
    input  logic [2:0]           funct3_i,
    input  logic [4:0]           rd_i,
    input  logic                 reg_write_i,
    output logic                 valid_o,
    output logic [XLEN-1:0]      result_o,
    output logic [4:0]           rd_o,
    output logic                 reg_write_o,
    output logic                 load_misaligned_o
);

    logic [XLEN-1:0] ld_data;
    logic            ld_mis;
    logic [1:0]      src;
    logic            src_ok;
    logic [XLEN-1:0] res_d;
    logic            mis_d;
    logic            we_d;

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .rdata      (mem_rdata_i),
        .off        (alu_result_i[1:0]),
        .funct3     (funct3_i),
        .data       (ld_data),
        .misaligned (ld_mis)
    );

    always_comb begin
        src                   = '0;
        src[SRC_SEL_W-1:0]    = result_src_i;
        src_ok                = (32'(result_src_i) < NUM_SRC);
        res_d                 = '0;
        mis_d                 = 1'b0;
        if (src_ok) begin
            case (result_src_e'(src))
                RES_ALU: res_d = alu_result_i;
                RES_MEM: begin
                    res_d = ld_data;
                    mis_d = ld_mis;
                end
                RES_PC4: res_d = pc_plus4_i;
                RES_IMM: res_d = imm_i;
                default: res_d = '0;
            endcase
        end
        we_d = valid_i & reg_write_i & (rd_i != 5'd0) & ~mis_d & src_ok;
    end

    // Flush outranks stall; result/rd are left untouched on flush since they are don't-care.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o           <= 1'b0;
            result_o          <= '0;
            rd_o              <= '0;
            reg_write_o       <= 1'b0;
            load_misaligned_o <= 1'b0;
        end else if (flush_i) begin
            valid_o           <= 1'b0;
            reg_write_o       <= 1'b0;
            load_misaligned_o <= 1'b0;
        end else if (!stall_i) begin
            valid_o           <= valid_i;
            result_o          <= res_d;
            rd_o              <= rd_i;
            reg_write_o       <= we_d;
            load_misaligned_o <= mis_d;
        end
    end

endmodule

// File: tb/tb_writeback_result_stage.sv
// Randomized self-checking bench for writeback_result_stage against a behavioural model.
module tb_writeback_result_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_i, flush_i, valid_i, reg_write_i;
    logic [1:0]  result_src_i;
    logic [31:0] alu_result_i, mem_rdata_i, pc_plus4_i, imm_i;
    logic [2:0]  funct3_i;
    logic [4:0]  rd_i;
    logic        valid_o, reg_write_o, load_misaligned_o;
    logic [31:0] result_o;
    logic [4:0]  rd_o;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;

    // model state
    logic        e_valid, e_we, e_mis, e_known;
    logic [31:0] e_res;
    logic [4:0]  e_rd;

    writeback_result_stage #(.XLEN(32), .NUM_SRC(4)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall_i           (stall_i),
        .flush_i           (flush_i),
        .valid_i           (valid_i),
        .result_src_i      (result_src_i),
        .alu_result_i      (alu_result_i),
        .mem_rdata_i       (mem_rdata_i),
        .pc_plus4_i        (pc_plus4_i),
        .imm_i             (imm_i),
        .funct3_i          (funct3_i),
        .rd_i              (rd_i),
        .reg_write_i       (reg_write_i),
        .valid_o           (valid_o),
        .result_o          (result_o),
        .rd_o              (rd_o),
        .reg_write_o       (reg_write_o),
        .load_misaligned_o (load_misaligned_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    task automatic model_reset();
        e_valid = 1'b0; e_we = 1'b0; e_mis = 1'b0; e_res = '0; e_rd = '0; e_known = 1'b1;
    endtask

    task automatic model_capture();
        int unsigned off, v;
        logic [31:0] r;
        logic        mis;
        off = 32'(alu_result_i[1:0]);
        r   = '0;
        mis = 1'b0;
        case (result_src_i)
            2'd0: r = alu_result_i;
            2'd1: begin
                case (funct3_i)
                    3'b000, 3'b100: begin
                        v = (mem_rdata_i >> (8 * off)) & 32'hFF;
                        r = (funct3_i == 3'b000 && v >= 128) ? v - 32'd256 : v;
                    end
                    3'b001, 3'b101: begin
                        if (off % 2 == 1) mis = 1'b1;
                        else begin
                            v = (mem_rdata_i >> (8 * off)) & 32'hFFFF;
                            r = (funct3_i == 3'b001 && v >= 32768) ? v - 32'd65536 : v;
                        end
                    end
                    3'b010: if (off != 0) mis = 1'b1; else r = mem_rdata_i;
                    default: r = '0;
                endcase
            end
            2'd2: r = pc_plus4_i;
            default: r = imm_i;
        endcase
        if (flush_i) begin
            e_valid = 1'b0; e_we = 1'b0; e_mis = 1'b0; e_known = 1'b0;
        end else if (!stall_i) begin
            e_valid = valid_i;
            e_res   = mis ? 32'd0 : r;
            e_rd    = rd_i;
            e_mis   = mis;
            e_we    = valid_i && reg_write_i && rd_i != 0 && !mis;
            e_known = 1'b1;
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_capture();
        #1;
        chk({tag, ".valid"}, 32'(valid_o), 32'(e_valid));
        chk({tag, ".we"},    32'(reg_write_o), 32'(e_we));
        chk({tag, ".mis"},   32'(load_misaligned_o), 32'(e_mis));
        if (e_known) begin
            chk({tag, ".res"}, result_o, e_res);
            chk({tag, ".rd"},  32'(rd_o), 32'(e_rd));
        end
    endtask

    task automatic set_in(input logic [1:0] src, input logic [31:0] alu, input logic [2:0] f3,
                          input logic [4:0] rd, input logic we, input logic vld);
        result_src_i = src; alu_result_i = alu; funct3_i = f3;
        rd_i = rd; reg_write_i = we; valid_i = vld; stall_i = 1'b0; flush_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        set_in(2'd0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0);
        mem_rdata_i = 32'h80FF_7F01; pc_plus4_i = 32'h104; imm_i = 32'hDEAD_B000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid", 32'(valid_o), 32'd0);
        chk("rst.res", result_o, 32'd0);
        chk("rst.we", 32'(reg_write_o), 32'd0);
        rst_n = 1'b1;

        set_in(2'd0, 32'h0000_1234, 3'b000, 5'd5, 1'b1, 1'b1);
        step("alu");
        chk("alu.const", result_o, 32'h1234);
        chk("alu.rd", 32'(rd_o), 32'd5);
        chk("alu.we1", 32'(reg_write_o), 32'd1);

        // async reset mid-cycle
        #2 rst_n = 1'b0;
        #1;
        chk("arst.valid", 32'(valid_o), 32'd0);
        chk("arst.res", result_o, 32'd0);
        chk("arst.rd", 32'(rd_o), 32'd0);
        chk("arst.we", 32'(reg_write_o), 32'd0);
        model_reset();
        #1 rst_n = 1'b1;
        step("postrst");

        set_in(2'd1, 32'h3, 3'b000, 5'd7, 1'b1, 1'b1); step("lb3");
        chk("lb3.const", result_o, 32'hFFFF_FF80);
        set_in(2'd1, 32'h1, 3'b100, 5'd7, 1'b1, 1'b1); step("lbu1");
        chk("lbu1.const", result_o, 32'h0000_007F);
        set_in(2'd1, 32'h2, 3'b001, 5'd7, 1'b1, 1'b1); step("lh2");
        chk("lh2.const", result_o, 32'hFFFF_80FF);
        set_in(2'd1, 32'h0, 3'b101, 5'd7, 1'b1, 1'b1); step("lhu0");
        chk("lhu0.const", result_o, 32'h0000_7F01);
        set_in(2'd1, 32'h0, 3'b010, 5'd7, 1'b1, 1'b1); step("lw0");
        chk("lw0.const", result_o, 32'h80FF_7F01);

        set_in(2'd1, 32'h1002, 3'b010, 5'd7, 1'b1, 1'b1); step("lwmis");
        chk("lwmis.flag", 32'(load_misaligned_o), 32'd1);
        chk("lwmis.res", result_o, 32'd0);
        set_in(2'd0, 32'h1, 3'b000, 5'd7, 1'b1, 1'b1); step("lwmis.clr");
        chk("lwmis.clr.flag", 32'(load_misaligned_o), 32'd0);
        set_in(2'd1, 32'h1, 3'b001, 5'd7, 1'b1, 1'b1); step("lhmis");
        chk("lhmis.we", 32'(reg_write_o), 32'd0);

        set_in(2'd0, 32'hA, 3'b000, 5'd3, 1'b1, 1'b1); step("capA");
        for (int i = 0; i < 3; i++) begin
            set_in(2'd0, 32'h100 + 32'(i), 3'b000, 5'd9, 1'b1, 1'b1);
            stall_i = 1'b1;
            step("stall");
            chk("stall.A", result_o, 32'hA);
        end
        set_in(2'd0, 32'h55, 3'b000, 5'd4, 1'b1, 1'b1);
        stall_i = 1'b1; flush_i = 1'b1;
        step("flushstall");
        chk("fs.we", 32'(reg_write_o), 32'd0);

        set_in(2'd0, 32'h77, 3'b000, 5'd0, 1'b1, 1'b1); step("rd0");
        set_in(2'd2, 32'h0, 3'b000, 5'd8, 1'b1, 1'b1); step("pc4");
        chk("pc4.const", result_o, 32'h104);
        set_in(2'd3, 32'h0, 3'b000, 5'd8, 1'b1, 1'b1); step("imm");
        chk("imm.const", result_o, 32'hDEAD_B000);
        set_in(2'd0, 32'h9, 3'b000, 5'd8, 1'b1, 1'b0); step("novalid");

        for (int i = 0; i < 400; i++) begin
            result_src_i = 2'($urandom_range(0, 3));
            alu_result_i = $urandom;
            mem_rdata_i  = $urandom;
            pc_plus4_i   = $urandom;
            imm_i        = $urandom;
            funct3_i     = 3'($urandom_range(0, 7));
            rd_i         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            reg_write_i  = ($urandom_range(0, 3) != 0);
            valid_i      = ($urandom_range(0, 4) != 0);
            stall_i      = ($urandom_range(0, 4) == 0);
            flush_i      = ($urandom_range(0, 7) == 0);
            step("rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
